// File: rtl/cpu_out_display.sv
// cpu_out_display: shows the CPU output port as decimal on a 4-digit multiplexed seven-segment display
module cpu_out_display #(
  parameter int REFRESH_DIV = 16,
  parameter bit LZ_BLANK    = 1'b0
) (
  input  logic        boardCLK,
  input  logic        reset,
  input  logic [7:0]  cpuOut,
  output logic [11:0] bcd,
  output logic        busy,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);
  typedef enum logic [1:0] {IDLE, CONV, LATCH} state_t;
  state_t state;
  logic [7:0] cap_val;
  logic [19:0] sr, adj;
  logic [2:0] step;
  logic [CW-1:0] cnt;
  logic [1:0] sel;
  logic [3:0] nib;
  logic blank;
  function automatic logic [3:0] add3(input logic [3:0] n);
    return n >= 4'd5 ? n + 4'd3 : n;
  endfunction
  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction
  // one double-dabble step: correct each BCD nibble, then shift
  assign adj = {add3(sr[19:16]), add3(sr[15:12]), add3(sr[11:8]), sr[7:0]};
  always_ff @(posedge boardCLK or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cap_val <= '0;
      sr      <= '0;
      step    <= '0;
      bcd     <= '0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (cpuOut != cap_val) begin
          cap_val <= cpuOut;
          sr      <= {12'b0, cpuOut};
          step    <= '0;
          busy    <= 1'b1;
          state   <= CONV;
        end
        CONV: begin
          sr    <= {adj[18:0], 1'b0};
          step  <= step + 3'd1;
          state <= step == 3'd7 ? LATCH : CONV;
        end
        LATCH: begin
          bcd   <= sr[19:8];
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge boardCLK or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      sel <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
      sel <= sel + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
  always_comb begin
    nib   = sel == 2'd0 ? bcd[3:0] : sel == 2'd1 ? bcd[7:4] : bcd[11:8];
    blank = sel == 2'd3 || (LZ_BLANK && sel == 2'd2 && bcd[11:8] == 4'd0) ||
            (LZ_BLANK && sel == 2'd1 && bcd[11:4] == 8'd0);
    seg   = blank ? 7'b1111111 : decode(nib);
  end
  assign an = ~(4'b0001 << sel);
  assign dp = 1'b1;
endmodule
